mips_multi_control: RTL and testbench

//  Multicycle MIPS main control FSM, directly upstream of the Mips_multi datapath.

---
 rtl/mips_multi_control.sv | 198 +++++++++++++++++++
 tb/tb_mips_multi_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_control.sv
// Main control FSM for the multicycle MIPS datapath: one state per clock,
// drives every datapath strobe/mux select and counts retired instructions.
module mips_multi_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    output logic             PC_write,
    output logic             Mem_write,
    output logic             lorD_mux,
    output logic             IR_write,
    output logic             Reg_Dst_mux,
    output logic             Mem_reg_mux,
    output logic             Reg_write,
    output logic             ALU_srcA_mux,
    output logic [1:0]       ALU_srcB_mux,
    output logic [3:0]       ALU_control,
    output logic             Pc_src_mux,
    output logic             Branch,
    output logic [3:0]       state_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC_R  = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDI_EX = 4'd9,
        ADDI_WB = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_aluHold;
    logic [CNT_W-1:0] r_retired;
    logic [3:0]       w_execAlu;
    logic             w_functOk;
    logic             w_retire;

    // R-type function decode, only consumed while in EXEC_R
    always_comb begin
        w_execAlu = ALU_ADD;
        w_functOk = 1'b1;
        case (Funct)
            6'b100000: w_execAlu = ALU_ADD;
            6'b100010: w_execAlu = ALU_SUB;
            6'b100100: w_execAlu = ALU_AND;
            6'b100101: w_execAlu = ALU_OR;
            6'b101010: w_execAlu = ALU_SLT;
            default:   w_functOk = 1'b0;
        endcase
    end

    always_comb begin
        w_next       = FETCH;
        w_retire     = 1'b0;
        PC_write     = 1'b0;
        Mem_write    = 1'b0;
        lorD_mux     = 1'b0;
        IR_write     = 1'b0;
        Reg_Dst_mux  = 1'b0;
        Mem_reg_mux  = 1'b0;
        Reg_write    = 1'b0;
        ALU_srcA_mux = 1'b0;
        ALU_srcB_mux = 2'b00;
        ALU_control  = ALU_ADD;
        Pc_src_mux   = 1'b0;
        Branch       = 1'b0;
        illegal_o    = 1'b0;
        state_o      = r_state;
        retired_o    = r_retired;
        case (r_state)
            FETCH: begin
                IR_write     = 1'b1;
                PC_write     = 1'b1;
                ALU_srcB_mux = 2'b01;
                w_next       = DECODE;
            end
            DECODE: begin
                ALU_srcB_mux = 2'b11;
                case (Op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXEC_R;
                    OP_BEQ:       w_next = BRANCH;
                    OP_ADDI:      w_next = ADDI_EX;
                    default:      illegal_o = 1'b1;
                endcase
            end
            MEMADR: begin
                ALU_srcA_mux = 1'b1;
                ALU_srcB_mux = 2'b10;
                w_next       = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                lorD_mux = 1'b1;
                w_next   = MEMWB;
            end
            MEMWB: begin
                Mem_reg_mux = 1'b1;
                Reg_write   = 1'b1;
                w_retire    = 1'b1;
            end
            MEMWR: begin
                lorD_mux  = 1'b1;
                Mem_write = 1'b1;
                w_retire  = 1'b1;
            end
            EXEC_R: begin
                ALU_srcA_mux = 1'b1;
                if (w_functOk) begin
                    ALU_control = w_execAlu;
                    w_next      = ALUWB;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            ALUWB: begin
                Reg_Dst_mux = 1'b1;
                Reg_write   = 1'b1;
                ALU_control = r_aluHold;
                w_retire    = 1'b1;
            end
            BRANCH: begin
                ALU_srcA_mux = 1'b1;
                ALU_control  = ALU_SUB;
                Pc_src_mux   = 1'b1;
                Branch       = 1'b1;
                w_retire     = 1'b1;
            end
            ADDI_EX: begin
                ALU_srcA_mux = 1'b1;
                ALU_srcB_mux = 2'b10;
                w_next       = ADDI_WB;
            end
            ADDI_WB: begin
                Reg_write = 1'b1;
                w_retire  = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
        // Reset silences the datapath immediately, before the state register clears
        if (reset) begin
            w_retire     = 1'b0;
            PC_write     = 1'b0;
            Mem_write    = 1'b0;
            lorD_mux     = 1'b0;
            IR_write     = 1'b0;
            Reg_Dst_mux  = 1'b0;
            Mem_reg_mux  = 1'b0;
            Reg_write    = 1'b0;
            ALU_srcA_mux = 1'b0;
            ALU_srcB_mux = 2'b00;
            ALU_control  = 4'b0000;
            Pc_src_mux   = 1'b0;
            Branch       = 1'b0;
            illegal_o    = 1'b0;
            state_o      = 4'd0;
            retired_o    = '0;
        end
    end

    // ALUWB replays the operation chosen in EXEC_R, after Funct may have moved on
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_retired <= '0;
            r_aluHold <= ALU_ADD;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
            if (r_state == EXEC_R)
                r_aluHold <= w_execAlu;
        end
    end

endmodule

// File: tb/tb_mips_multi_control.sv
// Self-checking bench for mips_multi_control: directed scenarios, then random
// instruction streams with occasional mid-instruction resets.
module tb_mips_multi_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       memw;
        logic       lord;
        logic       irw;
        logic       regdst;
        logic       memreg;
        logic       regw;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] alu;
        logic       pcsrc;
        logic       branch;
        logic       illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;

    logic        pcw0, memw0, lord0, irw0, regdst0, memreg0, regw0, srca0, pcsrc0, branch0, ill0;
    logic [1:0]  srcb0;
    logic [3:0]  alu0, st0;
    logic [15:0] ret0;
    logic        pcw1, memw1, lord1, irw1, regdst1, memreg1, regw1, srca1, pcsrc1, branch1, ill1;
    logic [1:0]  srcb1;
    logic [3:0]  alu1, st1;
    logic [3:0]  ret1;

    int   checks = 0;
    int   errors = 0;
    int   retiredModel = 0;
    ctl_t expQ[$];
    bit   retQ[$];

    mips_multi_control #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .PC_write(pcw0), .Mem_write(memw0), .lorD_mux(lord0), .IR_write(irw0),
        .Reg_Dst_mux(regdst0), .Mem_reg_mux(memreg0), .Reg_write(regw0),
        .ALU_srcA_mux(srca0), .ALU_srcB_mux(srcb0), .ALU_control(alu0),
        .Pc_src_mux(pcsrc0), .Branch(branch0), .state_o(st0),
        .illegal_o(ill0), .retired_o(ret0)
    );

    mips_multi_control #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .PC_write(pcw1), .Mem_write(memw1), .lorD_mux(lord1), .IR_write(irw1),
        .Reg_Dst_mux(regdst1), .Mem_reg_mux(memreg1), .Reg_write(regw1),
        .ALU_srcA_mux(srca1), .ALU_srcB_mux(srcb1), .ALU_control(alu1),
        .Pc_src_mux(pcsrc1), .Branch(branch1), .state_o(st1),
        .illegal_o(ill1), .retired_o(ret1)
    );

    always #5 clk = ~clk;

    function automatic ctl_t sample0();
        return {st0, pcw0, memw0, lord0, irw0, regdst0, memreg0, regw0, srca0,
                srcb0, alu0, pcsrc0, branch0, ill0};
    endfunction

    function automatic ctl_t sample1();
        return {st1, pcw1, memw1, lord1, irw1, regdst1, memreg1, regw1, srca1,
                srcb1, alu1, pcsrc1, branch1, ill1};
    endfunction

    function automatic ctl_t base(input int st);
        ctl_t c = '0;
        c.st  = 4'(st);
        c.alu = 4'b0010;
        return c;
    endfunction

    function automatic void push(input ctl_t c, input bit r);
        expQ.push_back(c);
        retQ.push_back(r);
    endfunction

    // Expected per-cycle control for one instruction, straight from the state table
    function automatic void buildSteps(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        logic [3:0] a;
        bit ok;
        expQ.delete();
        retQ.delete();
        c = base(0); c.irw = 1; c.pcw = 1; c.srcb = 2'b01; push(c, 0);
        c = base(1); c.srcb = 2'b11;
        case (op)
            6'b100011, 6'b101011: begin
                push(c, 0);
                c = base(2); c.srca = 1; c.srcb = 2'b10; push(c, 0);
                if (op == 6'b100011) begin
                    c = base(3); c.lord = 1; push(c, 0);
                    c = base(4); c.memreg = 1; c.regw = 1; push(c, 1);
                end else begin
                    c = base(5); c.lord = 1; c.memw = 1; push(c, 1);
                end
            end
            6'b000000: begin
                push(c, 0);
                ok = 1;
                a  = 4'b0010;
                case (fn)
                    6'b100000: a = 4'b0010;
                    6'b100010: a = 4'b0110;
                    6'b100100: a = 4'b0000;
                    6'b100101: a = 4'b0001;
                    6'b101010: a = 4'b0111;
                    default:   ok = 0;
                endcase
                c = base(6); c.srca = 1;
                if (ok) begin
                    c.alu = a; push(c, 0);
                    c = base(7); c.regdst = 1; c.regw = 1; c.alu = a; push(c, 1);
                end else begin
                    c.illegal = 1; push(c, 0);
                end
            end
            6'b000100: begin
                push(c, 0);
                c = base(8); c.srca = 1; c.alu = 4'b0110; c.pcsrc = 1; c.branch = 1; push(c, 1);
            end
            6'b001000: begin
                push(c, 0);
                c = base(9); c.srca = 1; c.srcb = 2'b10; push(c, 0);
                c = base(10); c.regw = 1; push(c, 1);
            end
            default: begin
                c.illegal = 1; push(c, 0);
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_ctl", 32'(sample0()), 32'd0);
        checkOutput("rst_ctl4", 32'(sample1()), 32'd0);
        checkOutput("rst_ret", 32'(ret0), 32'd0);
        checkOutput("rst_ret4", 32'(ret1), 32'd0);
    endtask

    // Runs one instruction from FETCH; abortAt >= 0 asserts reset at that step
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input int abortAt);
        buildSteps(op, fn);
        Op = op;
        Funct = fn;
        #1;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i == abortAt) begin
                reset = 1'b1;
                #1;
                checkReset();
                @(posedge clk); #1;
                checkReset();
                @(posedge clk); #1;
                reset = 1'b0;
                retiredModel = 0;
                #1;
                return;
            end
            checkOutput($sformatf("ctl_s%0d", expQ[i].st), 32'(sample0()), 32'(expQ[i]));
            checkOutput("ctl4", 32'(sample1()), 32'(expQ[i]));
            checkOutput("retired", 32'(ret0), 32'(retiredModel % 65536));
            checkOutput("retired4", 32'(ret1), 32'(retiredModel % 16));
            @(posedge clk); #1;
            if (retQ[i]) retiredModel++;
        end
    endtask

    initial begin
        int kind;
        int ab;
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] legalFn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        #1;
        checkReset();
        repeat (3) begin
            @(posedge clk); #1;
            checkReset();
        end
        reset = 1'b0;
        #1;

        applyStimulus(6'b000000, 6'b100010, -1);
        applyStimulus(6'b100011, 6'b000000, -1);
        applyStimulus(6'b101011, 6'b000000, -1);
        applyStimulus(6'b000100, 6'b000000, -1);
        applyStimulus(6'b001000, 6'b000000, -1);
        applyStimulus(6'b111111, 6'b000000, -1);
        applyStimulus(6'b000000, 6'b000001, -1);
        checkOutput("retired_after_directed", 32'(ret0), 32'd5);
        applyStimulus(6'b100011, 6'b000000, 3);
        checkOutput("retired_after_abort", 32'(ret0), 32'd0);
        checkOutput("state_after_abort", 32'(st0), 32'd0);

        repeat (16) applyStimulus(6'b000100, 6'b000000, -1);
        checkOutput("wrap4", 32'(ret1), 32'd0);
        checkOutput("nowrap16", 32'(ret0), 32'd16);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 8);
            fn   = 6'($urandom_range(0, 63));
            case (kind)
                0, 1: op = 6'b100011;
                2:    op = 6'b101011;
                3, 4: begin op = 6'b000000; fn = legalFn[$urandom_range(0, 4)]; end
                5:    op = 6'b000000;
                6:    op = 6'b000100;
                7:    op = 6'b001000;
                default: op = 6'($urandom_range(0, 63));
            endcase
            ab = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 4) : -1;
            applyStimulus(op, fn, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
